apbuart_stream_bridge: RTL

APB master that sits directly upstream of the APB UART wrapper (`apbuart_wrapper`) and drives its APB slave port. Out of reset it programs the control and scaler registers. It then polls the status register continuously, moving bytes between two valid/ready byte streams and the UART data register. System logic gets a byte-stream view of the UART with no software polling loop.

---
 rtl/apbuart_stream_bridge.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/apbuart_stream_bridge.sv
// APB master bridging two valid/ready byte streams to an APB UART.
// It configures the UART once, then polls status and moves RX/TX bytes.
module apbuart_stream_bridge #(
    parameter logic [31:0] UART_BASE   = 32'h0000_0000,
    parameter logic [31:0] CTRL_INIT   = 32'h0000_0003,
    parameter logic [31:0] SCALER_INIT = 32'd650
) (
    input  logic        clk,
    input  logic        rst,
    output logic        psel,
    output logic        penable,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done,
    output logic [2:0]  err_flags,
    input  logic        err_clr
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ERR_W  = 3;

    localparam logic [ADDR_W-1:0] OFF_DATA = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] OFF_STS  = 32'h0000_0004;
    localparam logic [ADDR_W-1:0] OFF_CTRL = 32'h0000_0008;
    localparam logic [ADDR_W-1:0] OFF_SCL  = 32'h0000_000C;

    typedef enum logic [2:0] {
        CFG_CTRL,
        CFG_SCL,
        IDLE,
        RD_STS,
        RD_DATA,
        WR_DATA
    } state_t;

    state_t              r_state;
    logic                r_psel;
    logic                r_penable;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_pwdata;
    logic                r_tx_ready;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_init_done;
    logic [ERR_W-1:0]    r_err_flags;
    logic [ADDR_W-1:0]   r_sts_q;
    logic                r_last_rx;

    logic                w_sts_done;
    logic [ADDR_W-1:0]   w_sts;
    logic                w_rx_pend;
    logic                w_tx_pend;
    logic                w_pick_rx;
    logic                w_pick_tx;
    logic                w_unused;

    // Status as seen this cycle: live read data while the status read completes.
    assign w_sts_done = r_psel && r_penable && pready && (r_state == RD_STS);
    assign w_sts      = w_sts_done ? prdata : r_sts_q;
    assign w_rx_pend  = w_sts[0] && !r_rx_valid;
    assign w_tx_pend  = tx_valid && !w_sts[9];
    assign w_pick_rx  = w_rx_pend && (!w_tx_pend || !r_last_rx);
    assign w_pick_tx  = w_tx_pend && !w_pick_rx;
    assign w_unused   = ^{w_sts[31:10], w_sts[8:7], w_sts[3:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= CFG_CTRL;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_tx_ready  <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_init_done <= 1'b0;
            r_err_flags <= '0;
            r_sts_q     <= '0;
            r_last_rx   <= 1'b0;
        end else begin
            r_tx_ready <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            // A flag reported in the same cycle as a clear survives it.
            r_err_flags <= (err_clr ? '0 : r_err_flags) | (w_sts_done ? w_sts[6:4] : '0);

            case (r_state)
                CFG_CTRL: begin
                    if (!r_psel) begin
                        r_psel   <= 1'b1;
                        r_paddr  <= UART_BASE + OFF_CTRL;
                        r_pwrite <= 1'b1;
                        r_pwdata <= CTRL_INIT;
                    end else if (!r_penable) begin
                        r_penable <= 1'b1;
                    end else if (pready) begin
                        r_state   <= CFG_SCL;
                        r_penable <= 1'b0;
                        r_paddr   <= UART_BASE + OFF_SCL;
                        r_pwdata  <= SCALER_INIT;
                    end
                end
                CFG_SCL: begin
                    if (!r_penable) begin
                        r_penable <= 1'b1;
                    end else if (pready) begin
                        r_state     <= IDLE;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_pwrite    <= 1'b0;
                        r_init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    r_state   <= RD_STS;
                    r_psel    <= 1'b1;
                    r_penable <= 1'b0;
                    r_pwrite  <= 1'b0;
                    r_paddr   <= UART_BASE + OFF_STS;
                end
                RD_STS: begin
                    if (!r_penable) begin
                        r_penable <= 1'b1;
                    end else if (pready) begin
                        r_sts_q   <= prdata;
                        r_penable <= 1'b0;
                        if (w_pick_rx) begin
                            r_state   <= RD_DATA;
                            r_paddr   <= UART_BASE + OFF_DATA;
                            r_pwrite  <= 1'b0;
                            r_last_rx <= 1'b1;
                        end else if (w_pick_tx) begin
                            r_state   <= WR_DATA;
                            r_paddr   <= UART_BASE + OFF_DATA;
                            r_pwrite  <= 1'b1;
                            r_pwdata  <= ADDR_W'(tx_data);
                            r_last_rx <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_psel  <= 1'b0;
                        end
                    end
                end
                RD_DATA: begin
                    if (!r_penable) begin
                        r_penable <= 1'b1;
                    end else if (pready) begin
                        r_state    <= IDLE;
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_rx_data  <= prdata[DATA_W-1:0];
                        r_rx_valid <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (!r_penable) begin
                        r_penable <= 1'b1;
                    end else if (pready) begin
                        r_state    <= IDLE;
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_pwrite   <= 1'b0;
                        r_tx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= CFG_CTRL;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign psel      = r_psel;
    assign penable   = r_penable;
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign tx_ready  = r_tx_ready;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign init_done = r_init_done;
    assign err_flags = r_err_flags;

endmodule
